// File: rtl/i2c_pkg.sv
// Shared encodings for the reduced I2C master status buses and the feeder FSM.
// No logic here; consumed by i2c_master_feeder and its bench.
package i2c_pkg;

    typedef enum logic [3:0] {
        MS_IDLE  = 4'd0,
        MS_START = 4'd1,
        MS_ADDR  = 4'd2,
        MS_READ  = 4'd3,
        MS_WRITE = 4'd4,
        MS_STOP  = 4'd5
    } main_state_e;

    typedef enum logic [4:0] {
        IS_DATA_7   = 5'd0,
        IS_DATA_6   = 5'd1,
        IS_DATA_5   = 5'd2,
        IS_DATA_4   = 5'd3,
        IS_DATA_3   = 5'd4,
        IS_DATA_2   = 5'd5,
        IS_DATA_1   = 5'd6,
        IS_DATA_0   = 5'd7,
        IS_DATA_ACT = 5'd8
    } i2c_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_XFER,
        ST_DRAIN
    } feeder_state_e;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous byte FIFO with push/pop/flush; head byte readable combinationally.
// Push while full is dropped, pop while empty is ignored, flush beats a same-cycle push.
module i2c_byte_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers are AW bits wide, so wrapping modulo DEPTH is free.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2c_master_feeder.sv
// Feeds host bytes to the reduced I2C master and returns read bytes; WR/RD one cycle after start.
// Host is backpressured by tx_ready (FIFO not full); status inputs are assumed synchronous.
module i2c_master_feeder
    import i2c_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int LEN_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             start_wr,
    input  logic             start_rd,
    input  logic [LEN_W-1:0] xfer_len,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             WR,
    output logic             RD,
    output logic [7:0]       m_data_out,
    input  logic [7:0]       m_data_in,
    input  logic [3:0]       main_state,
    input  logic [4:0]       i2c_state,
    input  logic             scl_fallingedge,
    input  logic             ack_status
);
    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_e    state_q;
    logic             wr_mode_q;
    logic [LEN_W-1:0] remaining_q;
    logic             wr_q, rd_q, busy_q, done_q, err_q, rx_valid_q;
    logic [7:0]       m_data_out_q, rx_data_q;

    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_pop, fifo_flush;
    logic          wr_go, rd_go, zero_go;
    logic          sfe_wr, nack_hit, next_pop, last_bit, rx_hit;

    always_comb begin
        wr_go    = (state_q == ST_IDLE) && start_wr && (xfer_len != '0) && (fifo_cnt != '0);
        rd_go    = (state_q == ST_IDLE) && !start_wr && start_rd && (xfer_len != '0);
        zero_go  = (state_q == ST_IDLE) && (start_wr || start_rd) && (xfer_len == '0);
        sfe_wr   = (state_q == ST_XFER) && wr_mode_q && scl_fallingedge && (main_state == MS_WRITE);
        nack_hit = sfe_wr && (i2c_state == IS_DATA_ACT) && ack_status;
        next_pop = sfe_wr && (i2c_state == IS_DATA_0) && (remaining_q != '0);
        last_bit = sfe_wr && (i2c_state == IS_DATA_7) && (remaining_q == '0);
        rx_hit   = (state_q == ST_XFER) && !wr_mode_q && scl_fallingedge
                   && (main_state == MS_READ) && (i2c_state == IS_DATA_ACT);
        fifo_pop   = wr_go || (next_pop && !fifo_empty);
        fifo_flush = nack_hit;
    end

    i2c_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_mode_q    <= 1'b0;
            remaining_q  <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rx_valid_q   <= 1'b0;
            m_data_out_q <= 8'h00;
            rx_data_q    <= 8'h00;
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_go || rd_go) begin
                        wr_mode_q   <= wr_go;
                        remaining_q <= xfer_len;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ARM;
                        if (wr_go) m_data_out_q <= fifo_head;
                    end else if (zero_go) begin
                        done_q <= 1'b1;
                    end
                end
                ST_ARM: begin
                    // Strobe rises one cycle after the first byte is already on m_data_out.
                    wr_q <= wr_mode_q;
                    rd_q <= !wr_mode_q;
                    if (main_state != MS_IDLE) begin
                        remaining_q <= remaining_q - 1'b1;
                        state_q     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (main_state == MS_IDLE) begin
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else if (nack_hit || (next_pop && fifo_empty)) begin
                        err_q   <= 1'b1;
                        wr_q    <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else if (next_pop) begin
                        m_data_out_q <= fifo_head;
                        remaining_q  <= remaining_q - 1'b1;
                    end else if (last_bit) begin
                        wr_q    <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else if (rx_hit) begin
                        rx_data_q  <= m_data_in;
                        rx_valid_q <= 1'b1;
                        if (remaining_q == '0) begin
                            rd_q    <= 1'b0;
                            state_q <= ST_DRAIN;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (main_state == MS_IDLE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by reset so the master sees them drop in the reset cycle itself.
    assign WR         = wr_q & ~reset;
    assign RD         = rd_q & ~reset;
    assign tx_ready   = !fifo_full;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign m_data_out = m_data_out_q;

endmodule

// File: tb/tb_i2c_master_feeder.sv
// Directed bench: models the reduced I2C master/slave bit sequencing around the feeder.
// Checks write, NACK, read, FIFO full, underrun, zero-length and mid-byte reset cases.
module tb_i2c_master_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       start_wr = 1'b0;
    logic       start_rd = 1'b0;
    logic [5:0] xfer_len = 6'd0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy, done, err, WR, RD;
    logic [7:0] m_data_out;
    logic [7:0] m_data_in = 8'h00;
    logic [3:0] main_state = 4'd0;
    logic [4:0] i2c_state = 5'd0;
    logic       scl_fallingedge = 1'b0;
    logic       ack_status = 1'b0;

    int checks = 0;
    int fails  = 0;
    int ncap, drop_byte, drop_bit, nrx_bytes;
    int rx_cnt = 0;
    logic [7:0] cap [64];
    logic [7:0] rd_vals [8];

    always #5 clock = ~clock;

    i2c_master_feeder #(.DEPTH(32), .LEN_W(6)) dut (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .start_wr(start_wr), .start_rd(start_rd), .xfer_len(xfer_len),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .err(err),
        .WR(WR), .RD(RD), .m_data_out(m_data_out), .m_data_in(m_data_in),
        .main_state(main_state), .i2c_state(i2c_state),
        .scl_fallingedge(scl_fallingedge), .ack_status(ack_status)
    );

    always @(negedge clock) if (rx_valid === 1'b1) rx_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic start(input logic wr, input logic [5:0] len);
        start_wr = wr;
        start_rd = !wr;
        xfer_len = len;
        tick();
        start_wr = 1'b0;
        start_rd = 1'b0;
    endtask

    // A write start of one byte must be refused when the FIFO holds nothing.
    task automatic expect_fifo_empty(input string tag);
        start(1'b1, 6'd1);
        check1(tag, busy, 1'b0);
    endtask

    task automatic stop_and_done();
        main_state = 4'd5;
        tick();
        tick();
        main_state = 4'd0;
        i2c_state  = 5'd0;
        tick();
        check1("done_pulse", done, 1'b1);
        tick();
        check1("done_once", done, 1'b0);
        check1("busy_after_done", busy, 1'b0);
    endtask

    // Master sends bytes while WR is still high after each acknowledge.
    task automatic run_write(input int nack_byte);
        logic wr_before;
        ncap = 0;
        drop_byte = 0;
        drop_bit = -1;
        main_state = 4'd1; tick();
        main_state = 4'd2; tick(); tick();
        main_state = 4'd4;
        for (int b = 1; b <= 40; b++) begin
            for (int k = 0; k <= 8; k++) begin
                i2c_state = k[4:0];
                tick();
                if (k == 0) begin
                    cap[ncap] = m_data_out;
                    ncap++;
                end
                tick();
                ack_status = (k == 8) && (b == nack_byte);
                scl_fallingedge = 1'b1;
                wr_before = WR;
                tick();
                scl_fallingedge = 1'b0;
                ack_status = 1'b0;
                if (wr_before && !WR && drop_byte == 0) begin
                    drop_byte = b;
                    drop_bit = k;
                end
                if (k == 8 && b == nack_byte) begin
                    check1("nack_err", err, 1'b1);
                    check1("nack_wr_low", WR, 1'b0);
                end
            end
            if (!WR) break;
        end
        stop_and_done();
    endtask

    task automatic run_read();
        nrx_bytes = 0;
        main_state = 4'd1; tick();
        main_state = 4'd2; tick(); tick();
        main_state = 4'd3;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k <= 8; k++) begin
                i2c_state = k[4:0];
                tick();
                if (k == 8) m_data_in = rd_vals[b];
                scl_fallingedge = 1'b1;
                tick();
                scl_fallingedge = 1'b0;
                if (k == 8) begin
                    check1("rx_valid_strobe", rx_valid, 1'b1);
                    check8("rx_data", rx_data, rd_vals[b]);
                end
            end
            nrx_bytes = b + 1;
            if (!RD) break;
        end
        stop_and_done();
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_tx_ready"}, tx_ready, 1'b1);
        check1({tag, "_wr"}, WR, 1'b0);
        check1({tag, "_rd"}, RD, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_rx_valid"}, rx_valid, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        check8({tag, "_m_data_out"}, m_data_out, 8'h00);
        check8({tag, "_rx_data"}, rx_data, 8'h00);
    endtask

    initial begin
        int rx_before;
        rd_vals[0] = 8'h10; rd_vals[1] = 8'h11; rd_vals[2] = 8'h12; rd_vals[3] = 8'h13;
        rd_vals[4] = 8'h14; rd_vals[5] = 8'h15; rd_vals[6] = 8'h16; rd_vals[7] = 8'h17;

        // Reset state
        tick(); tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // Write path A5 5A 00 FF
        push(8'hA5); push(8'h5A); push(8'h00); push(8'hFF);
        start(1'b1, 6'd4);
        check1("wr_busy_rise", busy, 1'b1);
        check8("wr_first_byte_setup", m_data_out, 8'hA5);
        check1("wr_not_yet", WR, 1'b0);
        tick();
        check1("wr_strobe", WR, 1'b1);
        run_write(0);
        check_int("wr_byte_count", ncap, 4);
        check8("wr_byte0", cap[0], 8'hA5);
        check8("wr_byte1", cap[1], 8'h5A);
        check8("wr_byte2", cap[2], 8'h00);
        check8("wr_byte3", cap[3], 8'hFF);
        check_int("wr_drop_byte", drop_byte, 4);
        check_int("wr_drop_bit", drop_bit, 0);
        check1("wr_err", err, 1'b0);
        expect_fifo_empty("wr_fifo_empty");

        // NACK on byte 2 of 4
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        start(1'b1, 6'd4);
        tick();
        run_write(2);
        check_int("nack_byte_count", ncap, 2);
        check8("nack_byte0", cap[0], 8'h11);
        check8("nack_byte1", cap[1], 8'h22);
        check1("nack_err_sticky", err, 1'b1);
        expect_fifo_empty("nack_fifo_flushed");

        // Read path 10 11 12
        rx_before = rx_cnt;
        start(1'b0, 6'd3);
        check1("rd_err_cleared", err, 1'b0);
        check1("rd_busy_rise", busy, 1'b1);
        tick();
        check1("rd_strobe", RD, 1'b1);
        check1("rd_no_wr", WR, 1'b0);
        run_read();
        check_int("rd_bytes", nrx_bytes, 3);
        check_int("rd_rx_pulses", rx_cnt - rx_before, 3);
        check1("rd_dropped", RD, 1'b0);

        // FIFO boundary: 33 bytes offered, 32 kept
        for (int i = 0; i <= 32; i++) begin
            tx_data  = i[7:0];
            tx_valid = 1'b1;
            tick();
            if (i == 30) check1("fifo_ready_31", tx_ready, 1'b1);
            if (i == 31) check1("fifo_full_32", tx_ready, 1'b0);
        end
        tx_valid = 1'b0;
        start(1'b1, 6'd32);
        tick();
        run_write(0);
        check_int("fifo_byte_count", ncap, 32);
        for (int i = 0; i < 32; i++) check8("fifo_byte", cap[i], i[7:0]);
        check1("fifo_no_underrun", err, 1'b0);
        check_int("fifo_drop_byte", drop_byte, 32);
        expect_fifo_empty("fifo_byte33_dropped");

        // Underrun: 2 bytes for a 3-byte write
        push(8'h77); push(8'h88);
        start(1'b1, 6'd3);
        tick();
        run_write(0);
        check1("udr_err", err, 1'b1);
        check_int("udr_byte_count", ncap, 2);
        check_int("udr_drop_byte", drop_byte, 2);
        check_int("udr_drop_bit", drop_bit, 7);

        // Zero-length starts
        start(1'b1, 6'd0);
        check1("zl_wr_done", done, 1'b1);
        check1("zl_wr_busy", busy, 1'b0);
        tick();
        check1("zl_wr_done_once", done, 1'b0);
        check1("zl_wr_never", WR, 1'b0);
        start(1'b0, 6'd0);
        check1("zl_rd_done", done, 1'b1);
        tick();
        check1("zl_rd_never", RD, 1'b0);

        // Reset in the middle of a byte
        push(8'h55); push(8'h66);
        start(1'b1, 6'd2);
        tick();
        main_state = 4'd1; tick();
        main_state = 4'd4; i2c_state = 5'd3; tick(); tick();
        check1("mid_wr_high", WR, 1'b1);
        reset = 1'b1;
        #1;
        check1("mid_wr_drop_now", WR, 1'b0);
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        main_state = 4'd0;
        i2c_state = 5'd0;
        tick();
        expect_fifo_empty("midrst_fifo_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master_feeder.md
# i2c_master_feeder

Synthesizable byte sequencer that sits directly upstream of the reduced I2C master (`I2C_wr_reduced`) and replaces the hand-written stimulus loop used in bench. Buffers host write bytes in a FIFO, drives the master's `WR`/`RD` strobes and data byte, and tracks the master's state outputs to advance, stop or abort. In read mode it returns each received byte to the host.

## Interface
- `DEPTH`, 32: TX FIFO depth in bytes, power of two, range 4..64.
- `LEN_W`, 6: width of the transfer-length field.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in 8: host byte to enqueue.
- `tx_valid` in 1: enqueue request.
- `tx_ready` out 1: FIFO not full.
- `start_wr` in 1: one-cycle pulse; begin a write of `xfer_len` bytes.
- `start_rd` in 1: one-cycle pulse; begin a read of `xfer_len` bytes.
- `xfer_len` in LEN_W: byte count, latched on start.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: one-cycle strobe qualifying `rx_data`.
- `busy` out 1: high from accepted start to `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky; NACK or underrun; cleared by the next accepted start.
- `WR`, `RD` out 1: master request strobes.
- `m_data_out` out 8: byte presented to the master.
- `m_data_in` in 8: byte assembled by the master in read mode.
- `main_state` in 4, `i2c_state` in 5, `scl_fallingedge` in 1, `ack_status` in 1: master status (`ack_status` 1 = NACK).

## Operation
- States: IDLE, ARM, XFER, DRAIN.
- IDLE:
  - `start_wr` accepted only if `xfer_len != 0` and FIFO non-empty. Pop the head byte into `m_data_out`, clear `err`, go to ARM.
  - `start_rd` accepted if `xfer_len != 0`. Go to ARM.
  - `xfer_len == 0`: no transfer; `done` pulses the next cycle.
  - Start while busy: ignored.
  - `start_wr` and `start_rd` in the same cycle: write wins.
- ARM: assert `WR` (write) or `RD` (read). When `main_state` leaves idle (0), load `remaining = xfer_len - 1` and go to XFER.
- XFER write, `main_state == write_status` (4):
  - On `scl_fallingedge` with `i2c_state == data_act` (8): if `ack_status == 1`, set `err`, drop `WR`, flush FIFO, go to DRAIN.
  - On `scl_fallingedge` with `i2c_state == data_0` (7) and `remaining != 0`: pop the next byte into `m_data_out` and decrement `remaining`.
    - If the FIFO is empty at that pop: set `err` (underrun), drop `WR`, go to DRAIN.
  - On `scl_fallingedge` with `i2c_state == data_7` (0) and `remaining == 0`: drop `WR`, go to DRAIN.
- XFER read, `main_state == read_status` (3):
  - On `scl_fallingedge` with `i2c_state == data_act`: `rx_data <= m_data_in`, pulse `rx_valid`.
    - If `remaining == 0`: drop `RD`, go to DRAIN.
    - Otherwise decrement `remaining`.
- DRAIN: wait for `main_state == idle_status` (0), pulse `done`, go to IDLE.
- FIFO:
  - Enqueue when `tx_valid && tx_ready`.
  - Simultaneous enqueue and pop: both occur.
  - Enqueue while full: dropped.
  - Flush overrides a same-cycle enqueue.
  - Occupancy counter width is `$clog2(DEPTH)+1`.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values: FSM IDLE, FIFO empty, `tx_ready` 1, `WR`/`RD`/`busy`/`done`/`rx_valid`/`err` 0, `m_data_out` 0x00, `rx_data` 0x00.
- Reset mid-transfer: everything returns to reset values the next cycle, and `WR`/`RD` drop immediately.
- `busy` rises the cycle after an accepted start.
- `m_data_out` is valid before `WR` rises and changes only at data_0 falling edges. This gives the master a full SCL phase of setup before data_7.
- `rx_valid` follows the qualifying `scl_fallingedge` by exactly 1 clock.
- `done` follows `main_state` returning to 0 by exactly 1 clock.
- Status inputs are synchronous to `clock` and are not resynchronized.

## Structure
- Package `i2c_pkg` holds:
  - `main_state` encodings (idle 0, start 1, address 2, read 3, write 4, stop 5).
  - `i2c_state` encodings (data_7 0 … data_0 7, data_act 8).
  - The feeder FSM state typedef.
- One sub-module, `i2c_byte_fifo`: synchronous FIFO parameterized by DEPTH, with push/pop/flush, full/empty and count.

## Test plan
- Write path: enqueue A5, 5A, 00, FF, `start_wr` with `xfer_len` = 4 against the behavioural slave.
  - Slave receives A5, 5A, 00, FF in order.
  - `WR` drops at the data_7 falling edge of byte 4; one `done` pulse; `err` = 0; FIFO empty.
- NACK: slave NACKs byte 2 of 4.
  - `err` = 1, `WR` low and FIFO flushed within 1 clock.
  - `done` pulses after `main_state` returns to 0.
- Read path: `start_rd` with `xfer_len` = 3; slave returns 10, 11, 12.
  - Exactly three `rx_valid` pulses carrying 10, 11, 12.
  - `RD` drops after the third byte.
- FIFO boundary: hold `tx_valid` with 0..DEPTH.
  - `tx_ready` falls after 32 bytes; byte 33 is dropped.
  - A subsequent 32-byte write sends 0..31 with no underrun.
- Underrun: enqueue 2 bytes, `start_wr` with `xfer_len` = 3.
  - `err` = 1 at the third pop; `WR` low; `done` follows.
- Edge starts:
  - `xfer_len` = 0 gives `done` next cycle with `WR`/`RD` never asserted.
  - `reset` pulsed mid-byte gives all outputs at reset values next cycle.
